// File: rtl/film_scan_pkg.sv
// Shared types and error codes for the film-transport step sequencer.
package film_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    RUN,
    HOME,
    HOLD,
    FAULT
  } fas_state_t;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_FLT   = 2'b01;
  localparam logic [1:0] ERR_HOME  = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

endpackage

// File: rtl/step_ramp_gen.sv
// STEP pulse generator with trapezoidal half-period ramp.
// Each full step is hp cycles high followed by hp cycles low. The half-period
// shrinks after every step until DIV_MIN, and grows back once the number of
// steps still to go is no larger than the number of ramp-up steps taken.
module step_ramp_gen #(
  parameter int STEP_W   = 16,
  parameter int DIV_W    = 24,
  parameter int DIV_MAX  = 500_000,
  parameter int DIV_MIN  = 50_000,
  parameter int RAMP_DEC = 5_000
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              halt,
  input  logic              stop_req,
  input  logic              ramp_en,
  input  logic [STEP_W-1:0] remaining,
  output logic              step,
  output logic              step_rise,
  output logic              step_fall_done
);

  localparam logic [DIV_W:0]   MIN_X  = (DIV_W+1)'(DIV_MIN);
  localparam logic [DIV_W:0]   MAX_X  = (DIV_W+1)'(DIV_MAX);
  localparam logic [DIV_W:0]   DEC_X  = (DIV_W+1)'(RAMP_DEC);
  localparam logic [DIV_W-1:0] HP_MIN = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] HP_MAX = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] HP_ONE = DIV_W'(1);

  logic              active;
  logic [DIV_W-1:0]  hp;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  hp_next;
  logic [STEP_W-1:0] acc;
  logic              acc_inc;

  // Saturating decrement: never goes below DIV_MIN, computed one bit wider.
  function automatic logic [DIV_W-1:0] hp_dec(input logic [DIV_W-1:0] h);
    logic [DIV_W:0] hx;
    hx = {1'b0, h};
    if (hx <= MIN_X + DEC_X) return HP_MIN;
    else                     return DIV_W'(hx - DEC_X);
  endfunction

  // Saturating increment: never exceeds DIV_MAX, computed one bit wider.
  function automatic logic [DIV_W-1:0] hp_inc(input logic [DIV_W-1:0] h);
    logic [DIV_W:0] hx;
    hx = {1'b0, h};
    if (hx + DEC_X >= MAX_X) return HP_MAX;
    else                     return DIV_W'(hx + DEC_X);
  endfunction

  assign step_fall_done = active & ~step & (cnt == '0);
  assign step_rise      = ~halt & ((~active & start) | (step_fall_done & ~stop_req));

  // Half-period for the next step: decelerate once the remaining steps fit the ramp.
  always_comb begin
    hp_next = hp;
    acc_inc = 1'b0;
    if (ramp_en) begin
      if (remaining <= acc) begin
        hp_next = hp_inc(hp);
      end else begin
        hp_next = hp_dec(hp);
        acc_inc = (hp > HP_MIN);
      end
    end
  end

  // Phase counter and STEP pin; halt drops STEP on the very next edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      active <= 1'b0;
      step   <= 1'b0;
      hp     <= HP_MAX;
      cnt    <= '0;
      acc    <= '0;
    end else if (halt) begin
      active <= 1'b0;
      step   <= 1'b0;
      cnt    <= '0;
    end else if (!active) begin
      if (start) begin
        active <= 1'b1;
        step   <= 1'b1;
        hp     <= HP_MAX;
        cnt    <= HP_MAX - HP_ONE;
        acc    <= '0;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - HP_ONE;
    end else if (step) begin
      step <= 1'b0;
      cnt  <= hp - HP_ONE;
    end else if (stop_req) begin
      active <= 1'b0;
    end else begin
      step <= 1'b1;
      hp   <= hp_next;
      cnt  <= hp_next - HP_ONE;
      if (acc_inc) acc <= acc + STEP_W'(1);
    end
  end

endmodule

// File: rtl/film_advance_seq.sv
// Command sequencer for the film-transport stepper driver: accepts move/home
// commands, wakes the driver, runs a ramped STEP train, homes, holds, sleeps.
import film_scan_pkg::*;

module film_advance_seq #(
  parameter int   STEP_W   = 16,
  parameter int   DIV_W    = 24,
  parameter int   DIV_MAX  = 500_000,
  parameter int   DIV_MIN  = 50_000,
  parameter int   RAMP_DEC = 5_000,
  parameter int   WAKE_CYC = 100_000,
  parameter int   HOLD_CYC = 10_000,
  parameter int   HOME_MAX = 40_000,
  parameter logic HOME_DIR = 1'b0
) (
  input  logic              clk_100MHz,
  input  logic              nrst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_home,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              mtr_step,
  output logic              mtr_dir,
  output logic              mtr_nen,
  output logic              mtr_nrst,
  output logic              mtr_slp,
  input  logic              mtr_nhome,
  input  logic              mtr_nflt
);

  localparam logic [31:0] WAKE_LD = 32'(WAKE_CYC - 1);
  localparam logic [31:0] HOLD_LD = 32'(HOLD_CYC - 1);

  fas_state_t        state;
  logic              nhome_p0, nhome_p1, nflt_p0, nflt_p1;
  logic [STEP_W-1:0] remaining;
  logic [31:0]       tmr;
  logic              home_mode, abort_lat, home_lat;
  logic              moving, flt_now, start, abort_now, home_now, stop_req;
  logic              step_rise, step_fall_done;

  // Two-flop synchronisers for the asynchronous sensor and fault inputs.
  always_ff @(posedge clk_100MHz or negedge nrst) begin
    if (!nrst) begin
      nhome_p0 <= 1'b1;
      nhome_p1 <= 1'b1;
      nflt_p0  <= 1'b1;
      nflt_p1  <= 1'b1;
    end else begin
      nhome_p0 <= mtr_nhome;
      nhome_p1 <= nhome_p0;
      nflt_p0  <= mtr_nflt;
      nflt_p1  <= nflt_p0;
    end
  end

  assign moving    = (state == RUN) || (state == HOME);
  assign flt_now   = ~nflt_p1 & (moving || (state == WAKE) || (state == HOLD));
  assign start     = (state == WAKE) && (tmr == '0) && !flt_now && !(home_mode && !nhome_p1);
  assign abort_now = moving & (abort | abort_lat);
  assign home_now  = moving & home_mode & (~nhome_p1 | home_lat);
  assign stop_req  = (remaining == '0) | abort_now | home_now;

  step_ramp_gen #(
    .STEP_W  (STEP_W),
    .DIV_W   (DIV_W),
    .DIV_MAX (DIV_MAX),
    .DIV_MIN (DIV_MIN),
    .RAMP_DEC(RAMP_DEC)
  ) u_ramp (
    .clk           (clk_100MHz),
    .nrst          (nrst),
    .start         (start),
    .halt          (flt_now),
    .stop_req      (stop_req),
    .ramp_en       (~home_mode),
    .remaining     (remaining),
    .step          (mtr_step),
    .step_rise     (step_rise),
    .step_fall_done(step_fall_done)
  );

  // Command FSM with registered handshake, status and driver-control pins.
  always_ff @(posedge clk_100MHz or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_OK;
      mtr_dir   <= 1'b0;
      mtr_nen   <= 1'b1;
      mtr_nrst  <= 1'b0;
      mtr_slp   <= 1'b0;
      remaining <= '0;
      tmr       <= '0;
      home_mode <= 1'b0;
      abort_lat <= 1'b0;
      home_lat  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (step_rise) remaining <= remaining - STEP_W'(1);
      if (abort_now) abort_lat <= 1'b1;
      if (home_now)  home_lat  <= 1'b1;
      if (flt_now) begin
        state     <= FAULT;
        cmd_ready <= 1'b1;
        busy      <= 1'b0;
        done      <= 1'b1;
        err       <= 1'b1;
        err_code  <= ERR_FLT;
        mtr_nen   <= 1'b1;
        mtr_nrst  <= 1'b0;
        mtr_slp   <= 1'b0;
      end else begin
        case (state)
          IDLE, FAULT: begin
            cmd_ready <= 1'b1;
            if (cmd_valid && cmd_ready) begin
              err       <= 1'b0;
              err_code  <= ERR_OK;
              abort_lat <= 1'b0;
              home_lat  <= 1'b0;
              home_mode <= cmd_home;
              remaining <= cmd_home ? STEP_W'(HOME_MAX) : cmd_steps;
              if (!cmd_home && cmd_steps == '0) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                state     <= WAKE;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
                tmr       <= WAKE_LD;
                mtr_nen   <= 1'b0;
                mtr_nrst  <= 1'b1;
                mtr_slp   <= 1'b1;
                mtr_dir   <= cmd_home ? HOME_DIR : cmd_dir;
              end
            end
          end
          WAKE: begin
            if (tmr != '0) begin
              tmr <= tmr - 32'd1;
            end else if (home_mode && !nhome_p1) begin
              state <= HOLD;
              tmr   <= HOLD_LD;
            end else begin
              state <= home_mode ? HOME : RUN;
            end
          end
          RUN, HOME: begin
            if (step_fall_done && stop_req) begin
              state <= HOLD;
              tmr   <= HOLD_LD;
              if (abort_now)                 err_code <= ERR_ABORT;
              else if (home_mode && !home_now) err_code <= ERR_HOME;
              else                           err_code <= ERR_OK;
            end
          end
          HOLD: begin
            if (tmr != '0) begin
              tmr <= tmr - 32'd1;
            end else begin
              state     <= IDLE;
              done      <= 1'b1;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              err       <= (err_code != ERR_OK);
              mtr_nen   <= 1'b1;
              mtr_nrst  <= 1'b0;
              mtr_slp   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_film_advance_seq.sv
// Directed bench for film_advance_seq using small timing parameters.
module tb_film_advance_seq;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cmd_valid, cmd_ready, cmd_home, cmd_dir;
  logic [15:0] cmd_steps;
  logic        abort, busy, done, err;
  logic [1:0]  err_code;
  logic        mtr_step, mtr_dir, mtr_nen, mtr_nrst, mtr_slp, mtr_nhome, mtr_nflt;

  int n_vec = 0;
  int n_mis = 0;

  film_advance_seq #(
    .STEP_W(16), .DIV_W(24), .DIV_MAX(10), .DIV_MIN(4), .RAMP_DEC(2),
    .WAKE_CYC(5), .HOLD_CYC(3), .HOME_MAX(6), .HOME_DIR(1'b0)
  ) dut (
    .clk_100MHz(clk), .nrst(nrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_home(cmd_home),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .abort(abort),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .mtr_step(mtr_step), .mtr_dir(mtr_dir), .mtr_nen(mtr_nen),
    .mtr_nrst(mtr_nrst), .mtr_slp(mtr_slp),
    .mtr_nhome(mtr_nhome), .mtr_nflt(mtr_nflt)
  );

  always #5 clk = ~clk;

  // Pin monitor: counts STEP rises, records high-phase lengths and event cycles.
  int   cyc = 0;
  int   rises = 0;
  int   hi_len = 0;
  int   last_fall_cyc = 0;
  int   done_cyc = 0;
  int   hp_q[$];
  logic step_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mtr_step && !step_q) begin
      rises++;
      hi_len = 0;
    end
    if (!mtr_step && step_q) begin
      hp_q.push_back(hi_len);
      last_fall_cyc = cyc;
    end
    if (mtr_step) hi_len++;
    if (done) done_cyc = cyc;
    step_q = mtr_step;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int acc_cyc = 0;

  task automatic issue(input logic home, input logic dir, input logic [15:0] steps);
    cmd_home  = home;
    cmd_dir   = dir;
    cmd_steps = steps;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int k;
    k = 0;
    while (done !== 1'b1 && k < max_cyc) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_rises(input string tag, input int base, input int n, input int max_cyc);
    int k;
    k = 0;
    while ((rises - base) < n && k < max_cyc) begin
      tick();
      k++;
    end
    chk(tag, rises - base, n);
  endtask

  int b_r, b_q, n;
  int exp8[8] = '{10, 8, 6, 4, 4, 6, 8, 10};
  int exp3[3] = '{10, 8, 10};

  initial begin
    nrst = 1'b0; cmd_valid = 1'b0; cmd_home = 1'b0; cmd_dir = 1'b0;
    cmd_steps = '0; abort = 1'b0; mtr_nhome = 1'b1; mtr_nflt = 1'b1;
    repeat (2) tick();
    chk("rst_step", mtr_step, 0);
    chk("rst_nen", mtr_nen, 1);
    chk("rst_nrst", mtr_nrst, 0);
    chk("rst_slp", mtr_slp, 0);
    chk("rst_busy_done_err", {busy, done, err, err_code}, 0);
    nrst = 1'b1;
    tick();
    chk("ready_after_rst", cmd_ready, 1);

    // 8-step move, dir=1: symmetric ramp 10,8,6,4,4,6,8,10
    b_r = rises; b_q = hp_q.size();
    issue(1'b0, 1'b1, 16'd8);
    chk("mv8_busy", busy, 1);
    chk("mv8_ready", cmd_ready, 0);
    chk("mv8_drv_on", {mtr_nen, mtr_nrst, mtr_slp}, 3'b011);
    wait_rises("mv8_first_rise", b_r, 1, 50);
    chk("mv8_wake_lat", cyc - acc_cyc, 5);
    chk("mv8_dir", mtr_dir, 1);
    wait_done("mv8_done", 400);
    chk("mv8_rises", rises - b_r, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("mv8_hp%0d", i), hp_q[b_q + i], exp8[i]);
    chk("mv8_done_gap", done_cyc - last_fall_cyc, 13);
    chk("mv8_err", {err, err_code}, 0);
    chk("mv8_busy_off", busy, 0);
    chk("mv8_nen_off", mtr_nen, 1);
    tick();
    chk("mv8_done_pulse", done, 0);

    // 3-step move: 10,8,10
    b_r = rises; b_q = hp_q.size();
    issue(1'b0, 1'b0, 16'd3);
    wait_done("mv3_done", 200);
    chk("mv3_rises", rises - b_r, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("mv3_hp%0d", i), hp_q[b_q + i], exp3[i]);
    chk("mv3_dir", mtr_dir, 0);

    // zero-step move: immediate done, driver never woken
    b_r = rises;
    issue(1'b0, 1'b1, 16'd0);
    chk("zero_done", done, 1);
    chk("zero_err", err, 0);
    chk("zero_nen", mtr_nen, 1);
    tick();
    chk("zero_done_pulse", done, 0);
    repeat (8) tick();
    chk("zero_no_step", rises - b_r, 0);
    chk("zero_nen_idle", mtr_nen, 1);

    // home, sensor drops after 5 steps
    b_r = rises;
    issue(1'b1, 1'b1, 16'd0);
    chk("home_dir", mtr_dir, 0);
    wait_rises("home_5", b_r, 5, 300);
    mtr_nhome = 1'b0;
    wait_done("home_done", 200);
    n = rises - b_r;
    chk("home_rises_5_6", (n >= 5 && n <= 6) ? 1 : 0, 1);
    chk("home_err", {err, err_code}, 0);
    mtr_nhome = 1'b1;
    repeat (3) tick();

    // home, sensor never seen: timeout after HOME_MAX=6 steps
    b_r = rises;
    issue(1'b1, 1'b0, 16'd0);
    wait_done("home_to_done", 400);
    chk("home_to_rises", rises - b_r, 6);
    chk("home_to_err", {err, err_code}, 3'b110);

    // home, already on sensor at wake exit: zero steps
    mtr_nhome = 1'b0;
    repeat (3) tick();
    b_r = rises;
    issue(1'b1, 1'b0, 16'd0);
    wait_done("home0_done", 50);
    chk("home0_rises", rises - b_r, 0);
    chk("home0_err", {err, err_code}, 0);
    mtr_nhome = 1'b1;
    repeat (3) tick();

    // abort during high phase of step 3 of 20
    b_r = rises;
    issue(1'b0, 1'b0, 16'd20);
    wait_rises("abort_3", b_r, 3, 200);
    abort = 1'b1;
    wait_done("abort_done", 200);
    abort = 1'b0;
    chk("abort_rises", rises - b_r, 3);
    chk("abort_err", {err, err_code}, 3'b111);

    // driver fault during RUN
    b_r = rises;
    issue(1'b0, 1'b1, 16'd20);
    wait_rises("flt_2", b_r, 2, 200);
    tick();
    mtr_nflt = 1'b0;
    repeat (3) tick();
    chk("flt_step", mtr_step, 0);
    chk("flt_drv_off", {mtr_nen, mtr_nrst, mtr_slp}, 3'b100);
    chk("flt_done", done, 1);
    chk("flt_err", {err, err_code}, 3'b101);
    chk("flt_ready", cmd_ready, 1);
    chk("flt_busy", busy, 0);
    tick();
    chk("flt_sticky", {done, err}, 2'b01);
    mtr_nflt = 1'b1;
    repeat (3) tick();
    issue(1'b0, 1'b0, 16'd0);
    chk("flt_clear_done", done, 1);
    chk("flt_clear_err", {err, err_code}, 0);

    // async reset in the middle of a step; command ignored while in reset
    b_r = rises;
    issue(1'b0, 1'b1, 16'd8);
    wait_rises("rst_mid", b_r, 2, 200);
    nrst = 1'b0;
    cmd_valid = 1'b1;
    #1;
    chk("rstm_step", mtr_step, 0);
    chk("rstm_drv", {mtr_nen, mtr_nrst, mtr_slp, mtr_dir}, 4'b1000);
    chk("rstm_status", {busy, done, err, err_code}, 0);
    repeat (3) tick();
    chk("rstm_hold_busy", busy, 0);
    cmd_valid = 1'b0;
    nrst = 1'b1;
    tick();
    chk("rstm_ready", cmd_ready, 1);
    chk("rstm_idle", {busy, mtr_nen, mtr_step}, 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
